// File: rtl/i2s_adc_rx_if.sv
// Codec-side I2S pins plus the published stereo sample bus of the ADC receiver.
// The slave modport is the receiver's view; the master modport drives the codec pins and consumes samples.
interface i2s_adc_rx_if;
  logic               AUD_BCLK;
  logic               AUD_ADCLRCK;
  logic               AUD_ADCDAT;
  logic signed [31:0] out_L;
  logic signed [31:0] out_R;
  logic               sample_valid;
  logic               frame_err;

  modport master (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  out_L, out_R, sample_valid, frame_err
  );

  modport slave (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output out_L, out_R, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronises the codec pins onto CLOCK_50 and deserialises
// each LRCK frame into a left-aligned signed 32-bit stereo pair with a valid strobe.
module i2s_adc_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  i2s_adc_rx_if.slave aud
);
  localparam int              CNT_W     = 6;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  // Pin vector order: [2] data, [1] lrck, [0] bclk.
  logic [2:0] pins;
  logic [2:0] sync_s;
  assign pins = {aud.AUD_ADCDAT, aud.AUD_ADCLRCK, aud.AUD_BCLK};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
      logic [2:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge CLOCK_50) begin
          if (reset) stage_q <= '0;
          else       stage_q <= pins;
        end
      end else begin : g_next
        always_ff @(posedge CLOCK_50) begin
          if (reset) stage_q <= '0;
          else       stage_q <= gen_sync[gi-1].stage_q;
        end
      end
    end
  endgenerate
  assign sync_s = gen_sync[SYNC_STAGES-1].stage_q;

  state_t              state_q, state_d;
  logic [2:0]          hist_q, hist_d;
  logic                bclk_rise_q, bclk_rise_d;
  logic                lrck_rise_q, lrck_rise_d;
  logic                lrck_fall_q, lrck_fall_d;
  logic                din_q, din_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [31:0]         hold_l_q, hold_l_d;
  logic [31:0]         out_l_q, out_l_d;
  logic [31:0]         out_r_q, out_r_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_err_q, frame_err_d;

  logic [CNT_W-1:0]    n_bits;
  logic [31:0]         slot_word;
  logic                short_slot;
  logic                lrck_edge;

  always_comb begin
    hist_d      = sync_s;
    bclk_rise_d = sync_s[0] & ~hist_q[0];
    lrck_rise_d = sync_s[1] & ~hist_q[1];
    lrck_fall_d = ~sync_s[1] & hist_q[1];
    din_d       = sync_s[2];

    // bit_cnt counts the delay bit too, so shifted bits = bit_cnt - 1 (saturates at DATA_W).
    n_bits     = (bit_cnt_q == '0) ? '0 : bit_cnt_q - CNT_W'(1);
    slot_word  = 32'(shift_q) << (CNT_W'(32) - n_bits);
    short_slot = (n_bits < FULL_BITS);
    lrck_edge  = lrck_rise_q | lrck_fall_q;

    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    hold_l_d       = hold_l_q;
    out_l_d        = out_l_q;
    out_r_d        = out_r_q;
    sample_valid_d = 1'b0;
    frame_err_d    = frame_err_q;

    // A bclk_rise coinciding with an LRCK edge is the delay bit of the new slot.
    if (lrck_edge) begin
      bit_cnt_d = bclk_rise_q ? CNT_W'(1) : '0;
    end else if (bclk_rise_q && (bit_cnt_q != CNT_MAX)) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (!lrck_edge && bclk_rise_q && (state_q != IDLE) &&
        (bit_cnt_q >= CNT_W'(1)) && (bit_cnt_q <= FULL_BITS)) begin
      shift_d = {shift_q[DATA_W-2:0], din_q};
    end

    unique case (state_q)
      IDLE: begin
        if (lrck_fall_q) begin
          state_d = LEFT;
          shift_d = '0;
        end
      end
      LEFT: begin
        if (lrck_rise_q) begin
          hold_l_d = slot_word;
          shift_d  = '0;
          state_d  = RIGHT;
          if (short_slot) frame_err_d = 1'b1;
        end else if (lrck_fall_q) begin
          state_d     = IDLE;
          shift_d     = '0;
          frame_err_d = 1'b1;
        end
      end
      RIGHT: begin
        if (lrck_fall_q) begin
          out_l_d        = hold_l_q;
          out_r_d        = slot_word;
          sample_valid_d = 1'b1;
          shift_d        = '0;
          state_d        = LEFT;
          if (short_slot) frame_err_d = 1'b1;
        end else if (lrck_rise_q) begin
          state_d     = IDLE;
          shift_d     = '0;
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      hist_q         <= '0;
      bclk_rise_q    <= 1'b0;
      lrck_rise_q    <= 1'b0;
      lrck_fall_q    <= 1'b0;
      din_q          <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      hold_l_q       <= '0;
      out_l_q        <= '0;
      out_r_q        <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      bclk_rise_q    <= bclk_rise_d;
      lrck_rise_q    <= lrck_rise_d;
      lrck_fall_q    <= lrck_fall_d;
      din_q          <= din_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold_l_q       <= hold_l_d;
      out_l_q        <= out_l_d;
      out_r_q        <= out_r_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign aud.out_L        = out_l_q;
  assign aud.out_R        = out_r_q;
  assign aud.sample_valid = sample_valid_q;
  assign aud.frame_err    = frame_err_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: drives I2S slots at BCLK = CLOCK_50/16 and
// checks published pairs, strobe timing and the sticky frame error flag.
module tb_i2s_adc_rx;
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_adc_rx_if aud();

  i2s_adc_rx #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .aud      (aud)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int vcount = 0;
  int consec = 0;
  int fall_cyc = 0;
  int v_cyc[$];
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (aud.sample_valid) begin
      vcount++;
      v_cyc.push_back(cyc);
      if (prev_v) consec++;
      $display("[cyc %0d] publish L=%h R=%h err=%0b", cyc, aud.out_L, aud.out_R, aud.frame_err);
    end
    prev_v = aud.sample_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One BCLK period: falling edge (data changes), 8 clocks low, 8 clocks high.
  task automatic send_bit(input logic b);
    aud.AUD_BCLK   = 1'b0;
    aud.AUD_ADCDAT = b;
    repeat (8) @(negedge clk);
    aud.AUD_BCLK = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One slot: delay bit then n data bits MSB first; optional 1-cycle reset before bit rst_at.
  task automatic send_slot(input logic lr, input int n, input logic [63:0] w, input int rst_at);
    if (!lr && aud.AUD_ADCLRCK) fall_cyc = cyc;
    aud.AUD_ADCLRCK = lr;
    send_bit(1'b0);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      send_bit(w[i]);
    end
  endtask

  initial begin
    int v0;
    int k0;
    reset           = 1'b1;
    aud.AUD_BCLK    = 1'b1;
    aud.AUD_ADCLRCK = 1'b1;
    aud.AUD_ADCDAT  = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_out_L", aud.out_L, 32'h0);
    check_eq("rst_out_R", aud.out_R, 32'h0);
    check_eq("rst_valid", 32'(aud.sample_valid), 32'h0);
    check_eq("rst_err", 32'(aud.frame_err), 32'h0);
    reset = 1'b0;

    // Startup mid-right-slot: nothing may publish until a full left+right pair.
    send_slot(1'b1, 15, 64'h0, -1);
    check_eq("startup_no_valid", 32'(vcount), 32'd0);
    check_eq("startup_out_L", aud.out_L, 32'h0);
    send_slot(1'b0, 32, 64'h12345678, -1);
    check_eq("startup_left_no_valid", 32'(vcount), 32'd0);
    send_slot(1'b1, 32, 64'hFEDCBA98, -1);

    // Next slot is the long-slot left; its LRCK fall publishes the nominal frame.
    send_slot(1'b0, 40, 64'h80000001FF, -1);
    check_eq("nom_count", 32'(vcount), 32'd1);
    check_eq("nom_L", aud.out_L, 32'h12345678);
    check_eq("nom_R", aud.out_R, 32'hFEDCBA98);
    check_eq("nom_err", 32'(aud.frame_err), 32'h0);
    check_eq("nom_latency", 32'(v_cyc[v_cyc.size()-1] - fall_cyc), 32'd4);

    send_slot(1'b1, 40, 64'h7FFFFFFFFF, -1);
    send_slot(1'b0, 32, 64'hAAAA5555, -1);
    check_eq("long_count", 32'(vcount), 32'd2);
    check_eq("long_L", aud.out_L, 32'h80000001);
    check_eq("long_R", aud.out_R, 32'h7FFFFFFF);
    check_eq("long_err", 32'(aud.frame_err), 32'h0);

    // Reset halfway through the right slot discards the frame.
    send_slot(1'b1, 32, 64'h5555AAAA, 16);
    check_eq("midrst_count", 32'(vcount), 32'd2);
    check_eq("midrst_L", aud.out_L, 32'h0);
    check_eq("midrst_R", aud.out_R, 32'h0);
    send_slot(1'b0, 32, 64'h00000010, -1);
    send_slot(1'b1, 32, 64'hFFFFFFF0, -1);

    // Back-to-back frames: left = n, right = -n; LRCK period = 2*33*16 = 1056 cycles.
    k0 = 0;
    for (int n = 1; n <= 8; n++) begin
      send_slot(1'b0, 32, 64'(n), -1);
      if (n == 1) begin
        check_eq("after_rst_count", 32'(vcount), 32'd3);
        check_eq("after_rst_L", aud.out_L, 32'h00000010);
        check_eq("after_rst_R", aud.out_R, 32'hFFFFFFF0);
        k0 = vcount;
      end else begin
        check_eq($sformatf("b2b%0d_L", n - 1), aud.out_L, 32'(n - 1));
        check_eq($sformatf("b2b%0d_R", n - 1), aud.out_R, 32'(-(n - 1)));
        check_eq($sformatf("b2b%0d_space", n - 1), 32'(v_cyc[vcount-1] - v_cyc[vcount-2]), 32'd1056);
      end
      send_slot(1'b1, 32, 64'(32'(-n)), -1);
    end

    // Short slot left starts here; its fall publishes frame 8.
    v0 = vcount;
    send_slot(1'b0, 24, 64'hABCDEF, -1);
    check_eq("b2b8_L", aud.out_L, 32'd8);
    check_eq("b2b8_R", aud.out_R, 32'hFFFFFFF8);
    check_eq("b2b8_space", 32'(v_cyc[vcount-1] - v_cyc[vcount-2]), 32'd1056);
    check_eq("b2b_count", 32'(vcount - k0), 32'd8);
    check_eq("b2b_err", 32'(aud.frame_err), 32'h0);

    send_slot(1'b1, 24, 64'h123456, -1);
    send_slot(1'b0, 32, 64'h11111111, -1);
    check_eq("short_count", 32'(vcount - v0), 32'd2);
    check_eq("short_L", aud.out_L, 32'hABCDEF00);
    check_eq("short_R", aud.out_R, 32'h12345600);
    check_eq("short_err", 32'(aud.frame_err), 32'h1);

    send_slot(1'b1, 32, 64'h22222222, -1);
    send_slot(1'b0, 32, 64'h0, -1);
    check_eq("good_after_short_L", aud.out_L, 32'h11111111);
    check_eq("good_after_short_R", aud.out_R, 32'h22222222);
    check_eq("err_sticky", 32'(aud.frame_err), 32'h1);
    check_eq("no_consec_valid", 32'(consec), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
